spi_bus_arbiter: RTL and testbench

//  Shares one spi_master instance among N_REQ requesters, e.g. keypad, sensor poll and status display.

---
 rtl/spi_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one spi_master among N_REQ requesters. Requests are granted
//   round-robin and only one transaction is in flight at a time. The master
//   is launched with a one-cycle active-low start. The arbiter then tracks
//   the master's busy flag and returns the received word to the granted
//   requester.
//
// Ports
//   CLOCK_50     in   system clock
//   rst_n        in   asynchronous active-low reset
//   req          in   [N_REQ]         level request per requester, held until ack
//   req_data     in   [N_REQ*DATA_W]  TX word per requester, i at [i*DATA_W +: DATA_W]
//   ack          out  [N_REQ]         one-cycle completion pulse to the granted requester
//   err          out                  valid with ack; 1 = busy-wait or transfer timeout
//   rsp_data     out  [DATA_W]        RX word, valid in the ack cycle, held until next ack
//   dev_sel      out  [N_REQ]         one-hot device select, 0 when idle
//   active       out                  1 from grant until return to idle
//   spi_start_n  out                  master start, low for exactly one cycle
//   spi_tx       out  [DATA_W]        master data_in, stable from grant to idle
//   spi_busy     in                   master busy
//   spi_rx       in   [DATA_W]        master data_out
module spi_bus_arbiter #(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BUSY_WAIT   = 16,
  parameter int unsigned TIMEOUT_CYC = 250000000
) (
  input  logic                      CLOCK_50,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [N_REQ-1:0]          dev_sel,
  output logic                      active,
  output logic                      spi_start_n,
  output logic [DATA_W-1:0]         spi_tx,
  input  logic                      spi_busy,
  input  logic [DATA_W-1:0]         spi_rx
);

  localparam int unsigned        IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [31:0]        BUSY_LAST    = 32'(BUSY_WAIT - 1);
  localparam logic [31:0]        TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   SEL_ZERO     = N_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_B, S_XFER, S_DONE, S_DRAIN
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [31:0]         cnt_reg, cnt_next, cnt_inc;
  logic                err_flag_reg, err_flag_next;
  logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
  logic [N_REQ-1:0]    dev_sel_reg, dev_sel_next;
  logic                active_reg, active_next;
  logic [DATA_W-1:0]   spi_tx_reg, spi_tx_next;

  logic [DATA_W-1:0]   req_word [N_REQ];
  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand_idx;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: first set request starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_idx = IDX_W'((32'(rr_ptr_reg) + i) % N_REQ);
      if (!grant_found && req[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Counter saturates instead of wrapping.
  assign cnt_inc = (cnt_reg == 32'hFFFF_FFFF) ? cnt_reg : cnt_reg + 32'd1;

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    cnt_next      = cnt_reg;
    err_flag_next = err_flag_reg;
    rsp_data_next = rsp_data_reg;
    dev_sel_next  = dev_sel_reg;
    active_next   = active_reg;
    spi_tx_next   = spi_tx_reg;
    case (state_reg)
      S_IDLE: begin
        if (grant_found) begin
          spi_tx_next  = req_word[grant_idx];
          dev_sel_next = SEL_ZERO << grant_idx;
          active_next  = 1'b1;
          rr_ptr_next  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          state_next   = S_START;
        end
      end
      S_START: begin
        cnt_next   = '0;
        state_next = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (spi_busy) begin
          cnt_next   = '0;
          state_next = S_XFER;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_reg == BUSY_LAST) begin
            err_flag_next = 1'b1;
            rsp_data_next = '0;
            state_next    = S_DONE;
          end
        end
      end
      S_XFER: begin
        if (!spi_busy) begin
          // rsp_data is loaded on entry to DONE so it is valid in the ack cycle.
          err_flag_next = 1'b0;
          rsp_data_next = spi_rx;
          state_next    = S_DONE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_reg == TIMEOUT_LAST) begin
            err_flag_next = 1'b1;
            rsp_data_next = '0;
            state_next    = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // After a timeout the master is still running; keep its device selected.
        if (!spi_busy) begin
          dev_sel_next = '0;
          active_next  = 1'b0;
          state_next   = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      rr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      err_flag_reg <= 1'b0;
      rsp_data_reg <= '0;
      dev_sel_reg  <= '0;
      active_reg   <= 1'b0;
      spi_tx_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      cnt_reg      <= cnt_next;
      err_flag_reg <= err_flag_next;
      rsp_data_reg <= rsp_data_next;
      dev_sel_reg  <= dev_sel_next;
      active_reg   <= active_next;
      spi_tx_reg   <= spi_tx_next;
    end
  end

  // The master is level-sensitive on start, so start is low only in START.
  assign spi_start_n = (state_reg != S_START);
  assign ack         = (state_reg == S_DONE) ? dev_sel_reg : '0;
  assign err         = (state_reg == S_DONE) && err_flag_reg;
  assign rsp_data    = rsp_data_reg;
  assign dev_sel     = dev_sel_reg;
  assign active      = active_reg;
  assign spi_tx      = spi_tx_reg;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter
//   Directed bench for spi_bus_arbiter with a simple spi_master model.
//   The model raises busy on the edge that sees start low, holds it for
//   m_len cycles, then drops it and presents m_rx.
module tb_spi_bus_arbiter;
  localparam int N_REQ  = 3;
  localparam int DATA_W = 16;
  localparam int BW     = 16;
  localparam int TO     = 100;

  logic                    CLOCK_50 = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    err;
  logic [DATA_W-1:0]       rsp_data;
  logic [N_REQ-1:0]        dev_sel;
  logic                    active;
  logic                    spi_start_n;
  logic [DATA_W-1:0]       spi_tx;
  logic                    spi_busy;
  logic [DATA_W-1:0]       spi_rx;

  spi_bus_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .BUSY_WAIT(BW), .TIMEOUT_CYC(TO)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .rsp_data(rsp_data), .dev_sel(dev_sel),
    .active(active), .spi_start_n(spi_start_n), .spi_tx(spi_tx),
    .spi_busy(spi_busy), .spi_rx(spi_rx)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Master model
  bit                m_en;
  int                m_len;
  logic [DATA_W-1:0] m_rx;
  logic [DATA_W-1:0] m_tx_seen;
  int                m_left;

  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy  <= 1'b0;
      spi_rx    <= '0;
      m_left    <= 0;
      m_tx_seen <= '0;
    end else if (!spi_start_n && m_en) begin
      spi_busy  <= 1'b1;
      m_left    <= m_len;
      m_tx_seen <= spi_tx;
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_left == 1) begin
      m_left   <= 0;
      spi_busy <= 1'b0;
      spi_rx   <= m_rx;
    end
  end

  int n_start = 0;
  int n_ack   = 0;
  logic [N_REQ-1:0] sel_at_start = '0;
  always @(negedge CLOCK_50) begin
    if (!spi_start_n) begin
      n_start      <= n_start + 1;
      sel_at_start <= dev_sel;
    end
    if (ack != 0) n_ack <= n_ack + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [N_REQ-1:0]  got_ack;
  logic              got_err;
  logic [DATA_W-1:0] got_rsp;
  int                got_cyc;

  task automatic wait_start(input string tag, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLOCK_50);
      if (!spi_start_n) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_start_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int max_cyc);
    got_cyc = -1;
    got_ack = '0;
    got_err = 1'b0;
    got_rsp = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge CLOCK_50);
      if (ack != 0) begin
        got_cyc = i;
        got_ack = ack;
        got_err = err;
        got_rsp = rsp_data;
        break;
      end
    end
    check({tag, "_ack_seen"}, 32'(got_cyc > 0), 32'd1);
    $display("[TB] %s: ack=%b err=%0d rsp=%h tx_seen=%h cycles=%0d",
             tag, got_ack, got_err, got_rsp, m_tx_seen, got_cyc);
  endtask

  int s0, a0, bad, el;
  logic [DATA_W-1:0] exp_tx [4];

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0;
    m_en = 1'b1; m_len = 5; m_rx = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rsp", 32'(rsp_data), 32'd0);
    check("rst_sel_active", {28'd0, dev_sel, active}, 32'd0);
    check("rst_start_n", 32'(spi_start_n), 32'd1);
    check("rst_tx", 32'(spi_tx), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Round-robin with all requests held: 0,1,2,0
    req_data = {16'h3333, 16'h2222, 16'h1111};
    exp_tx[0] = 16'h1111; exp_tx[1] = 16'h2222; exp_tx[2] = 16'h3333; exp_tx[3] = 16'h1111;
    m_len = 4; m_rx = 16'h5A5A;
    s0 = n_start; a0 = n_ack;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack($sformatf("rr%0d", k), 100);
      check($sformatf("rr%0d_ack", k), 32'(got_ack), 32'(1 << (k % 3)));
      check($sformatf("rr%0d_tx", k), 32'(m_tx_seen), 32'(exp_tx[k]));
      check($sformatf("rr%0d_rsp", k), 32'(got_rsp), 32'h5A5A);
      if (k == 3) req = '0;
    end
    repeat (4) @(negedge CLOCK_50);
    check("rr_starts", 32'(n_start - s0), 32'd4);
    check("rr_acks", 32'(n_ack - a0), 32'd4);

    // Single request on requester 0
    req_data[15:0] = 16'hDEAD; m_rx = 16'hBEEF; m_len = 5;
    s0 = n_start;
    req = 3'b001;
    wait_ack("single", 100);
    req = '0;
    check("single_ack", 32'(got_ack), 32'b001);
    check("single_err", 32'(got_err), 32'd0);
    check("single_rsp", 32'(got_rsp), 32'hBEEF);
    check("single_tx", 32'(m_tx_seen), 32'hDEAD);
    check("single_sel", 32'(sel_at_start), 32'b001);
    repeat (4) @(negedge CLOCK_50);
    check("single_starts", 32'(n_start - s0), 32'd1);
    check("single_idle", {28'd0, dev_sel, active}, 32'd0);
    check("single_rsp_held", 32'(rsp_data), 32'hBEEF);

    // Master never raises busy: busy-wait timeout
    m_en = 1'b0;
    req = 3'b010;
    wait_start("bw", 50);
    wait_ack("bw", 100);
    req = '0;
    check("bw_cycles", 32'(got_cyc), 32'(BW + 1));
    check("bw_ack", 32'(got_ack), 32'b010);
    check("bw_err", 32'(got_err), 32'd1);
    check("bw_rsp", 32'(got_rsp), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    check("bw_idle", {28'd0, dev_sel, active}, 32'd0);
    m_en = 1'b1;

    // Busy stuck high for 300 cycles: transfer timeout, then drain
    m_len = 300; m_rx = 16'h9999;
    s0 = n_start;
    req = 3'b100;
    wait_start("to", 50);
    wait_ack("to", 400);
    req = '0;
    check("to_cycles", 32'(got_cyc), 32'(TO + 2));
    check("to_err", 32'(got_err), 32'd1);
    check("to_rsp", 32'(got_rsp), 32'd0);
    bad = 0; el = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge CLOCK_50);
      if (!active) begin
        el = i;
        break;
      end
      if (dev_sel != 3'b100) bad++;
    end
    check("to_drain_cycles", 32'(el), 32'd200);
    check("to_sel_held", 32'(bad), 32'd0);
    check("to_starts", 32'(n_start - s0), 32'd1);

    // Reset in the middle of a transfer
    m_len = 50;
    req = 3'b001;
    wait_start("rst", 50);
    repeat (5) @(negedge CLOCK_50);
    check("rst_mid_xfer_active", 32'(active), 32'd1);
    rst_n = 1'b0;
    req = '0;
    #1;
    check("rstx_sel_active", {28'd0, dev_sel, active}, 32'd0);
    check("rstx_start_n", 32'(spi_start_n), 32'd1);
    check("rstx_tx", 32'(spi_tx), 32'd0);
    check("rstx_ack_err", {28'd0, ack, err}, 32'd0);
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
    req_data[31:16] = 16'h1234; m_len = 4; m_rx = 16'h4321;
    req = 3'b010;
    wait_ack("post_rst", 100);
    req = '0;
    check("post_rst_ack", 32'(got_ack), 32'b010);
    check("post_rst_rsp", 32'(got_rsp), 32'h4321);
    check("post_rst_tx", 32'(m_tx_seen), 32'h1234);
    repeat (3) @(negedge CLOCK_50);

    // Request dropped and data changed mid-transfer
    req_data[47:32] = 16'hCAFE; m_len = 20; m_rx = 16'h7777;
    s0 = n_start;
    req = 3'b100;
    wait_start("drop", 50);
    repeat (3) @(negedge CLOCK_50);
    req = '0;
    req_data[47:32] = 16'h0BAD;
    @(negedge CLOCK_50);
    check("drop_tx_stable", 32'(spi_tx), 32'hCAFE);
    wait_ack("drop", 100);
    check("drop_ack", 32'(got_ack), 32'b100);
    check("drop_err", 32'(got_err), 32'd0);
    check("drop_rsp", 32'(got_rsp), 32'h7777);
    check("drop_tx", 32'(m_tx_seen), 32'hCAFE);
    repeat (4) @(negedge CLOCK_50);
    check("drop_idle", {28'd0, dev_sel, active}, 32'd0);
    check("drop_starts", 32'(n_start - s0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
